// File: rtl/pll_clock_supervisor_if.sv
// Bundle between the PLL clock supervisor and its PLL / HDMI pipeline neighbours.
// The supervisor takes the slave side; the PLL/board model takes the master side.
interface pll_clock_supervisor_if #(
  parameter int CNT_W = 12
);
  logic             lock;
  logic             pclk_toggle;
  logic             pll_reset;
  logic             sys_reset;
  logic [CNT_W-1:0] freq_count;
  logic             freq_valid;
  logic [3:0]       retry_count;

  modport master (
    output lock, pclk_toggle,
    input  pll_reset, sys_reset, freq_count, freq_valid, retry_count
  );

  modport slave (
    input  lock, pclk_toggle,
    output pll_reset, sys_reset, freq_count, freq_valid, retry_count
  );
endinterface

// File: rtl/pll_clock_supervisor.sv
// Sequences the HDMI PLL: reset pulse, lock wait, pixel-clock frequency check,
// stable-lock hold-off, then releases the pipeline reset; any fault re-arms.
//
// state       | meaning
// S_PLL_RST   | pll_reset held high for PLL_RST_CYCLES
// S_WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT for lock
// S_MEASURE   | first measurement window after lock
// S_STABLE    | windows continue, lock must hold for STABLE_CYCLES
// S_RUN       | pipeline out of reset, windows continue
module pll_clock_supervisor #(
  parameter int PLL_RST_CYCLES = 27,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int WINDOW         = 2700,
  parameter int EXP_MIN        = 460,
  parameter int EXP_MAX        = 468,
  parameter int STABLE_CYCLES  = 27000,
  parameter int CNT_W          = 12
) (
  input  logic clkin,
  input  logic reset,
  pll_clock_supervisor_if.slave bus
);

  localparam int TMR_MAX = (LOCK_TIMEOUT > STABLE_CYCLES) ?
                           ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES) :
                           ((STABLE_CYCLES > PLL_RST_CYCLES) ? STABLE_CYCLES : PLL_RST_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int WIN_W = $clog2(WINDOW + 1);

  localparam logic [TMR_W-1:0] RST_TC    = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_TC   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_TC = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(EXP_MAX);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_MEASURE,
    S_STABLE,
    S_RUN
  } state_t;

  state_t           state;
  logic             lock_meta, lock_s;
  logic             tog_s1, tog_s2, tog_s3;
  logic [TMR_W-1:0] timer;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;

  logic             tog_edge;
  logic [CNT_W-1:0] edge_next;
  logic             active, win_last, win_done, in_range, fail;
  logic [3:0]       retry_next;

  always_comb begin
    tog_edge   = tog_s2 ^ tog_s3;
    edge_next  = (tog_edge && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
    active     = (state == S_MEASURE) || (state == S_STABLE) || (state == S_RUN);
    win_last   = (win_cnt == WIN_LAST);
    // a window only completes while lock holds, so lock loss discards its result
    win_done   = active && lock_s && win_last;
    in_range   = (edge_next >= CNT_MIN) && (edge_next <= CNT_MAX);
    fail       = ((state == S_WAIT_LOCK) && !lock_s && (timer == LOCK_TC)) ||
                 (active && !lock_s) ||
                 (win_done && !in_range);
    retry_next = (bus.retry_count == 4'hF) ? 4'hF : bus.retry_count + 1'b1;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state           <= S_PLL_RST;
      lock_meta       <= 1'b0;
      lock_s          <= 1'b0;
      tog_s1          <= 1'b0;
      tog_s2          <= 1'b0;
      tog_s3          <= 1'b0;
      timer           <= '0;
      win_cnt         <= '0;
      edge_cnt        <= '0;
      bus.pll_reset   <= 1'b1;
      bus.sys_reset   <= 1'b1;
      bus.freq_count  <= '0;
      bus.freq_valid  <= 1'b0;
      bus.retry_count <= '0;
    end else begin
      lock_meta <= bus.lock;
      lock_s    <= lock_meta;
      tog_s1    <= bus.pclk_toggle;
      tog_s2    <= tog_s1;
      tog_s3    <= tog_s2;

      if (active) begin
        win_cnt  <= win_last ? '0 : win_cnt + 1'b1;
        edge_cnt <= win_last ? '0 : edge_next;
      end

      if (win_done) begin
        bus.freq_count <= edge_next;
        bus.freq_valid <= in_range;
      end

      if (fail) begin
        state           <= S_PLL_RST;
        timer           <= '0;
        bus.pll_reset   <= 1'b1;
        bus.sys_reset   <= 1'b1;
        bus.retry_count <= retry_next;
        if (state == S_RUN) bus.freq_valid <= 1'b0;
      end else begin
        case (state)
          S_PLL_RST: begin
            if (timer == RST_TC) begin
              state         <= S_WAIT_LOCK;
              timer         <= '0;
              bus.pll_reset <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              state    <= S_MEASURE;
              win_cnt  <= '0;
              edge_cnt <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_MEASURE: begin
            if (win_done) begin
              state <= S_STABLE;
              timer <= '0;
            end
          end
          S_STABLE: begin
            if (timer == STABLE_TC) begin
              state         <= S_RUN;
              bus.sys_reset <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_RUN: begin
          end
          default: begin
            state         <= S_PLL_RST;
            timer         <= '0;
            bus.pll_reset <= 1'b1;
            bus.sys_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_clock_supervisor.sv
// Directed bring-up / fault scenarios for pll_clock_supervisor with a randomly
// phased pixel toggle; expectations come from a cycle timeline and edge log.
module tb_pll_clock_supervisor;

  localparam int RST_C = 4;
  localparam int TMO   = 50;
  localparam int WIN   = 64;
  localparam int EMIN  = 8;
  localparam int EMAX  = 10;
  localparam int STAB  = 200;
  localparam int CNT_W = 12;
  localparam int PER   = RST_C + TMO;
  // an input driven at the negedge after posedge N is acted on at posedge N+3
  localparam int LAT   = 3;

  logic clkin = 1'b0;
  logic reset = 1'b1;

  pll_clock_supervisor_if #(.CNT_W(CNT_W)) bus ();

  pll_clock_supervisor #(
    .PLL_RST_CYCLES(RST_C),
    .LOCK_TIMEOUT  (TMO),
    .WINDOW        (WIN),
    .EXP_MIN       (EMIN),
    .EXP_MAX       (EMAX),
    .STABLE_CYCLES (STAB),
    .CNT_W         (CNT_W)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clkin = ~clkin;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int next_tog = 0;
  int tog_per  = 7;
  bit tog_en   = 1'b0;
  int tog_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clkin cycle; drives the toggle at the negedge and logs when it moved
  task automatic tick();
    @(negedge clkin);
    cyc++;
    if (tog_en && cyc >= next_tog) begin
      bus.pclk_toggle = ~bus.pclk_toggle;
      tog_q.push_back(cyc);
      next_tog = cyc + tog_per;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  function automatic int edges_in(input int lo, input int hi);
    int n = 0;
    foreach (tog_q[i]) if (tog_q[i] >= lo && tog_q[i] <= hi) n++;
    return (n > 4095) ? 4095 : n;
  endfunction

  // toggles counted by the window closing at posedge m+64*(j+1), where m is measure entry
  function automatic int win_edges(input int m, input int j);
    return edges_in(m + 1 - LAT + WIN * j, m - LAT + WIN * (j + 1));
  endfunction

  initial begin
    int r, l, m, m2, m3, m4, d, d2, p, a, w_prev;
    bus.lock        = 1'b0;
    bus.pclk_toggle = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_pll_reset",   bus.pll_reset,   1);
    chk("rst_sys_reset",   bus.sys_reset,   1);
    chk("rst_freq_count",  bus.freq_count,  0);
    chk("rst_freq_valid",  bus.freq_valid,  0);
    chk("rst_retry_count", bus.retry_count, 0);

    // lock never arrives: periodic re-pulse, retry count saturates
    reset = 1'b0;
    r = cyc;
    for (int t = 0; t <= 17 * PER; t++) begin
      run_to(r + t);
      chk("tmo_pll_reset", bus.pll_reset, ((t % PER) < RST_C) ? 1 : 0);
      chk("tmo_retry", bus.retry_count, (t / PER > 15) ? 15 : t / PER);
      chk("tmo_sys_reset", bus.sys_reset, 1);
    end

    // nominal bring-up with a toggle every 7 cycles at a random phase
    tog_en   = 1'b1;
    tog_per  = 7;
    next_tog = cyc + 1 + $urandom_range(0, 6);
    reset = 1'b1;
    tick();
    chk("rearm_retry_clear", bus.retry_count, 0);
    reset = 1'b0;
    r = cyc;
    run_to(r + RST_C - 1);
    chk("nom_pll_reset_hi", bus.pll_reset, 1);
    run_to(r + RST_C);
    chk("nom_pll_reset_lo", bus.pll_reset, 0);
    run_to(r + RST_C + 10);
    bus.lock = 1'b1;
    l = cyc;
    m = l + LAT;
    run_to(m + WIN - 1);
    chk("nom_pre_window_count", bus.freq_count, 0);
    chk("nom_pre_window_valid", bus.freq_valid, 0);
    run_to(m + WIN);
    chk("nom_win0_count", bus.freq_count, win_edges(m, 0));
    chk("nom_win0_valid", bus.freq_valid, 1);
    run_to(m + 2 * WIN);
    chk("nom_win1_count", bus.freq_count, win_edges(m, 1));
    run_to(m + WIN + STAB - 1);
    chk("nom_sys_reset_held", bus.sys_reset, 1);
    run_to(m + WIN + STAB);
    chk("nom_sys_reset_rel", bus.sys_reset, 0);
    chk("nom_retry", bus.retry_count, 0);
    chk("nom_pll_reset", bus.pll_reset, 0);

    // lock drops for 3 cycles mid-window while running
    d = m + 5 * WIN + $urandom_range(8, 40);
    run_to(d - 1);
    w_prev = win_edges(m, 4);
    chk("loss_pre_count", bus.freq_count, w_prev);
    run_to(d);
    bus.lock = 1'b0;
    run_to(d + 2);
    chk("loss_sys_reset_still_lo", bus.sys_reset, 0);
    run_to(d + 3);
    bus.lock = 1'b1;
    chk("loss_sys_reset", bus.sys_reset, 1);
    chk("loss_pll_reset", bus.pll_reset, 1);
    chk("loss_retry", bus.retry_count, 1);
    chk("loss_freq_valid", bus.freq_valid, 0);
    chk("loss_freq_count", bus.freq_count, w_prev);
    run_to(d + 3 + RST_C);
    chk("loss_pll_reset_lo", bus.pll_reset, 0);
    m2 = d + 3 + RST_C + 1;
    run_to(m2 + WIN);
    chk("relock_count", bus.freq_count, win_edges(m2, 0));
    chk("relock_valid", bus.freq_valid, 1);
    run_to(m2 + WIN + STAB);
    chk("relock_sys_reset", bus.sys_reset, 0);

    // lock_s low in the last cycle of window 5; that window runs fast and is discarded
    run_to(m2 + 5 * WIN + 1 - LAT);
    tog_per = 5;
    w_prev = win_edges(m2, 4);
    d2 = m2 + 6 * WIN - LAT;
    run_to(d2);
    bus.lock = 1'b0;
    tog_per  = 4;
    run_to(d2 + 2);
    chk("glitch_pre_count", bus.freq_count, w_prev);
    run_to(d2 + 3);
    bus.lock = 1'b1;
    chk("glitch_count_kept", bus.freq_count, w_prev);
    chk("glitch_pll_reset", bus.pll_reset, 1);
    chk("glitch_sys_reset", bus.sys_reset, 1);
    chk("glitch_retry", bus.retry_count, 2);
    chk("glitch_valid", bus.freq_valid, 0);

    // toggle every 4 cycles: window out of range, back to PLL reset
    m3 = d2 + 3 + RST_C + 1;
    run_to(m3 + WIN - 1);
    chk("oor_pre_pll_reset", bus.pll_reset, 0);
    run_to(m3 + WIN);
    chk("oor_count", bus.freq_count, win_edges(m3, 0));
    chk("oor_valid", bus.freq_valid, 0);
    chk("oor_pll_reset", bus.pll_reset, 1);
    chk("oor_sys_reset", bus.sys_reset, 1);
    chk("oor_retry", bus.retry_count, 3);

    // recover with lock already high, then reset asynchronously mid-stable
    p = cyc;
    tog_per = 7;
    m4 = p + RST_C + 1;
    run_to(m4 + WIN);
    chk("rec_count", bus.freq_count, win_edges(m4, 0));
    chk("rec_valid", bus.freq_valid, 1);
    a = m4 + WIN + $urandom_range(20, 150);
    run_to(a);
    chk("stable_sys_reset", bus.sys_reset, 1);
    chk("stable_retry", bus.retry_count, 3);
    reset = 1'b1;
    #1;
    chk("async_pll_reset", bus.pll_reset, 1);
    chk("async_sys_reset", bus.sys_reset, 1);
    chk("async_retry", bus.retry_count, 0);
    chk("async_freq_valid", bus.freq_valid, 0);
    chk("async_freq_count", bus.freq_count, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
